// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_mem
//  Description : AXI4 memory-mapped responder backed by a MEM_DEPTH x DATA_WIDTH
//                word array. Independent write (AW/W/B) and read (AR/R) FSMs,
//                one burst of each in flight, OKAY/SLVERR responses.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_slave_mem #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // write address
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // write response
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // read address
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    // read data
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BPB   = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BPB);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    // Any address bit at or above TOP set means the beat lies beyond the array.
    localparam int TOP   = LSB + IDX_W;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(BPB);
    localparam logic [2:0]            SIZE_FULL   = 3'(LSB);
    localparam logic [1:0]            BURST_INCR  = 2'b01;
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write channel state ----------------
    wstate_t               wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [7:0]            wbeat_q, wbeat_d;
    logic                  wincr_q, wincr_d;
    logic                  willegal_q, willegal_d;
    logic                  werr_q, werr_d;
    logic                  mem_we;

    // ---------------- read channel state ----------------
    rstate_t               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [7:0]            rbeat_q, rbeat_d;
    logic                  rincr_q, rincr_d;
    logic                  rillegal_q, rillegal_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;

    // Burst legality is decided once at the address handshake.
    logic w_aw_illegal;
    logic w_ar_illegal;
    assign w_aw_illegal = awburst[1] | (awsize != SIZE_FULL);
    assign w_ar_illegal = arburst[1] | (arsize != SIZE_FULL);

    // Current write beat decode.
    logic [IDX_W-1:0] w_widx;
    logic             w_winrange;
    logic             w_wlast_beat;
    assign w_widx       = waddr_q[LSB +: IDX_W];
    assign w_winrange   = (waddr_q >> TOP) == '0;
    assign w_wlast_beat = (wbeat_q == wlen_q);

    // Read beat about to be launched: beat 0 comes straight from AR, later
    // beats from the advanced burst address. Single shared read port.
    logic [ADDR_WIDTH-1:0] w_rnext_addr;
    logic [ADDR_WIDTH-1:0] w_rsel_addr;
    logic                  w_rsel_illegal;
    logic                  w_rok;
    logic [DATA_WIDTH-1:0] w_rd_word;
    assign w_rnext_addr   = rincr_q ? (raddr_q + ADDR_STEP) : raddr_q;
    assign w_rsel_addr    = (rstate_q == R_IDLE) ? araddr : w_rnext_addr;
    assign w_rsel_illegal = (rstate_q == R_IDLE) ? w_ar_illegal : rillegal_q;
    assign w_rok          = !w_rsel_illegal && ((w_rsel_addr >> TOP) == '0);
    assign w_rd_word      = mem[w_rsel_addr[LSB +: IDX_W]];

    // Write FSM next-state: latch AW, accept beats until len, then respond.
    always_comb begin
        wstate_d   = wstate_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wbeat_d    = wbeat_q;
        wincr_d    = wincr_q;
        willegal_d = willegal_q;
        werr_d     = werr_q;
        mem_we     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (awvalid) begin
                    wid_d      = awid;
                    waddr_d    = awaddr;
                    wlen_d     = awlen;
                    wincr_d    = (awburst == BURST_INCR);
                    willegal_d = w_aw_illegal;
                    wbeat_d    = 8'd0;
                    werr_d     = 1'b0;
                    wstate_d   = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we = !willegal_q && w_winrange;
                    // A wlast mismatch is flagged but the beat is still stored.
                    if (willegal_q || !w_winrange || (wlast != w_wlast_beat)) begin
                        werr_d = 1'b1;
                    end
                    if (wincr_q) begin
                        waddr_d = waddr_q + ADDR_STEP;
                    end
                    wbeat_d = wbeat_q + 8'd1;
                    if (w_wlast_beat) begin
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q   <= W_IDLE;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wbeat_q    <= '0;
            wincr_q    <= 1'b0;
            willegal_q <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            wid_q      <= wid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wbeat_q    <= wbeat_d;
            wincr_q    <= wincr_d;
            willegal_q <= willegal_d;
            werr_q     <= werr_d;
        end
    end

    // Storage array: byte-lane write, never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BPB; b++) begin
                if (wstrb[b]) begin
                    mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM next-state: launch beat 0 on AR, advance a beat per R handshake.
    always_comb begin
        rstate_d   = rstate_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rbeat_d    = rbeat_q;
        rincr_d    = rincr_q;
        rillegal_d = rillegal_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        case (rstate_q)
            R_IDLE: begin
                if (arvalid) begin
                    rid_d      = arid;
                    raddr_d    = araddr;
                    rlen_d     = arlen;
                    rincr_d    = (arburst == BURST_INCR);
                    rillegal_d = w_ar_illegal;
                    rbeat_d    = 8'd0;
                    rdata_d    = w_rok ? w_rd_word : '0;
                    rresp_d    = w_rok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d    = (arlen == 8'd0);
                    rstate_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        raddr_d = w_rnext_addr;
                        rbeat_d = rbeat_q + 8'd1;
                        rdata_d = w_rok ? w_rd_word : '0;
                        rresp_d = w_rok ? RESP_OKAY : RESP_SLVERR;
                        rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read FSM registers; beat outputs are registered so they hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q   <= R_IDLE;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rbeat_q    <= '0;
            rincr_q    <= 1'b0;
            rillegal_q <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rlast_q    <= 1'b0;
        end else begin
            rstate_q   <= rstate_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rbeat_q    <= rbeat_d;
            rincr_q    <= rincr_d;
            rillegal_q <= rillegal_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    assign awready = (wstate_q == W_IDLE);
    assign wready  = (wstate_q == W_DATA);
    assign bvalid  = (wstate_q == W_RESP);
    assign bid     = wid_q;
    assign bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;

    assign arready = (rstate_q == R_IDLE);
    assign rvalid  = (rstate_q == R_DATA);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_slave_mem
//  Description : Self-checking bench for axi_slave_mem against a word-array
//                reference model; directed cases plus randomized bursts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_slave_mem;

    localparam int DEPTH     = 256;
    localparam int BPB       = 8;
    localparam int MEM_BYTES = DEPTH * BPB;
    localparam int TMO       = 100;

    logic        clk;
    logic        rst_n;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    axi_slave_mem dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: one entry per word, plus per-burst stimulus buffers.
    logic [63:0] model [DEPTH];
    logic [63:0] wd    [256];
    logic [7:0]  ws    [256];
    bit          wflip [256];
    logic [63:0] rd_q [$];
    logic [1:0]  rr_q [$];
    logic [1:0]  last_bresp;
    int          bp_b = 0;
    int          bp_r = 0;

    function automatic logic [63:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? 64'(a) : 64'(a) + 64'(i) * BPB;
    endfunction

    function automatic bit beat_ok(input logic [63:0] a, input logic [1:0] burst, input logic [2:0] size);
        return (burst < 2) && (size == 3'd3) && (a < MEM_BYTES);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit          err = 0;
        int          t;
        logic [63:0] a;
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < TMO) begin step(); t++; end
        if (t >= TMO) begin chk("aw_timeout", 0, 1); awvalid = 1'b0; return; end
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) ^ wflip[i]; wvalid = 1'b1;
            t = 0;
            while (!wready && t < TMO) begin step(); t++; end
            if (t >= TMO) begin chk("w_timeout", 0, 1); wvalid = 1'b0; return; end
            step();
            wvalid = 1'b0; wlast = 1'b0;
            a = beat_addr(addr, burst, i);
            if (beat_ok(a, burst, size)) begin
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) model[a[10:3]][b*8 +: 8] = wd[i][b*8 +: 8];
            end else begin
                err = 1;
            end
            if (wflip[i]) err = 1;
        end
        t = 0;
        while (!bvalid && t < TMO) begin step(); t++; end
        if (t >= TMO) begin chk("b_timeout", 0, 1); return; end
        last_bresp = bresp;
        chk("bid", 64'(bid), 64'(id));
        chk("bresp", 64'(bresp), err ? 64'd2 : 64'd0);
        for (int k = 0; k < bp_b; k++) begin
            chk("b_hold_awready", 64'(awready), 0);
            step();
            chk("b_hold", {bvalid, bid, bresp}, {1'b1, id, err, 1'b0});
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("b_done", {bvalid, awready}, 2'b01);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
        int          t;
        logic [63:0] a, ed;
        logic [1:0]  er;
        bit          ok;
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < TMO) begin step(); t++; end
        if (t >= TMO) begin chk("ar_timeout", 0, 1); arvalid = 1'b0; return; end
        step();
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!rvalid && t < TMO) begin step(); t++; end
            if (t >= TMO) begin chk("r_timeout", 0, 1); return; end
            a  = beat_addr(addr, burst, i);
            ok = beat_ok(a, burst, size);
            ed = ok ? model[a[10:3]] : 64'd0;
            er = ok ? 2'b00 : 2'b10;
            chk("rid", 64'(rid), 64'(id));
            chk("rdata", rdata, ed);
            chk("rresp_rlast", {rresp, rlast}, {er, (i == len)});
            rd_q.push_back(rdata);
            rr_q.push_back(rresp);
            for (int k = $urandom_range(0, bp_r); k > 0; k--) begin
                step();
                chk("r_hold_data", rdata, ed);
                chk("r_hold_ctl", {rvalid, rresp, rlast}, {1'b1, er, (i == len)});
            end
            rready = 1'b1;
            step();
            rready = 1'b0;
        end
        chk("r_done", {rvalid, arready}, 2'b01);
    endtask

    function automatic void clear_w();
        for (int i = 0; i < 256; i++) begin
            wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; wflip[i] = 0;
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] saved;
        int          len;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [2:0]  size;

        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {awready, arready, wready, bvalid, rvalid, rlast}, 6'b110000);
        chk("rst_ids", {bid, bresp, rid, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        step();

        // Fill the whole array through one long INCR burst so every word is known.
        clear_w();
        do_write(4'd0, 32'h0, 255, 3'd3, 2'b01);

        // Single write / read.
        clear_w();
        wd[0] = 64'hDEADBEEF_CAFEF00D;
        do_write(4'd3, 32'h10, 0, 3'd3, 2'b01);
        chk("t1_bresp", 64'(last_bresp), 0);
        rd_q.delete(); rr_q.delete();
        do_read(4'd3, 32'h10, 0, 3'd3, 2'b01);
        chk("t1_data", rd_q[0], 64'hDEADBEEF_CAFEF00D);

        // INCR burst of four.
        for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
        do_write(4'd1, 32'h40, 3, 3'd3, 2'b01);
        rd_q.delete(); rr_q.delete();
        do_read(4'd1, 32'h40, 3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) chk("t2_beat", rd_q[i], 64'(i + 1));

        // Strobes and FIXED.
        clear_w();
        wd[0] = 64'h11111111_11111111;
        do_write(4'd2, 32'h80, 0, 3'd3, 2'b01);
        wd[0] = 64'hFFFFFFFF_FFFFFFFF; ws[0] = 8'h0F;
        do_write(4'd2, 32'h80, 0, 3'd3, 2'b01);
        rd_q.delete(); rr_q.delete();
        do_read(4'd2, 32'h80, 0, 3'd3, 2'b01);
        chk("t3_strb", rd_q[0], 64'h11111111_FFFFFFFF);
        clear_w();
        wd[0] = 64'hA; wd[1] = 64'hB; wd[2] = 64'hC;
        do_write(4'd2, 32'h88, 2, 3'd3, 2'b00);
        rd_q.delete(); rr_q.delete();
        do_read(4'd2, 32'h88, 0, 3'd3, 2'b01);
        chk("t3_fixed", rd_q[0], 64'hC);

        // Error responses.
        clear_w();
        saved = model[8'h20];
        do_write(4'd4, 32'h100, 0, 3'd3, 2'b10);
        chk("t4_wrap_bresp", 64'(last_bresp), 2);
        rd_q.delete(); rr_q.delete();
        do_read(4'd4, 32'h100, 0, 3'd3, 2'b01);
        chk("t4_wrap_unchanged", rd_q[0], saved);
        rd_q.delete(); rr_q.delete();
        do_read(4'd5, 32'(MEM_BYTES - 8), 1, 3'd3, 2'b01);
        chk("t4_oor_resp", {rr_q[0], rr_q[1]}, 4'b0010);
        chk("t4_oor_data", rd_q[1], 0);
        clear_w();
        wflip[0] = 1;
        do_write(4'd6, 32'h180, 1, 3'd3, 2'b01);
        chk("t4_early_wlast", 64'(last_bresp), 2);
        do_write(4'd6, 32'h180, 0, 3'd2, 2'b01);
        chk("t4_narrow", 64'(last_bresp), 2);

        // Back-pressure.
        clear_w();
        bp_b = 5; bp_r = 2;
        do_write(4'd7, 32'h1C0, 3, 3'd3, 2'b01);
        do_read(4'd7, 32'h1C0, 3, 3'd3, 2'b01);
        bp_b = 0; bp_r = 0;

        // Concurrent write and read bursts on disjoint regions.
        clear_w();
        fork
            do_write(4'd8, 32'h200, 3, 3'd3, 2'b01);
            do_read(4'd9, 32'h400, 3, 3'd3, 2'b01);
        join

        // Reset in the middle of a write and a read burst.
        awid = 4'd2; awaddr = 32'h300; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'd2; araddr = 32'h300; arlen = 8'd3; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        step();
        awvalid = 1'b0; arvalid = 1'b0;
        wdata = 64'h0123_4567_89AB_CDEF; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        model[8'h60] = 64'h0123_4567_89AB_CDEF;
        chk("mid_busy", {awready, arready, wready, rvalid}, 4'b0011);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", {awready, arready, wready, bvalid, rvalid, rlast}, 6'b110000);
        chk("mid_rst_ids", {bid, bresp, rid, rresp}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_no_bresp", 64'(bvalid), 0);
        rd_q.delete(); rr_q.delete();
        do_read(4'd2, 32'h300, 1, 3'd3, 2'b01);
        chk("mid_kept", rd_q[0], 64'h0123_4567_89AB_CDEF);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            len   = $urandom_range(0, 7);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: burst = 2'b01;
                6, 7, 8:          burst = 2'b00;
                default:          burst = 2'b11;
            endcase
            size = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd3;
            case ($urandom_range(0, 6))
                0:       addr = 32'(MEM_BYTES - 8 * $urandom_range(1, 4));
                1:       addr = 32'h8000_0000 + 32'(8 * $urandom_range(0, 15));
                default: addr = 32'(8 * $urandom_range(0, 255));
            endcase
            for (int i = 0; i < 8; i++) begin
                wd[i]    = {$urandom, $urandom};
                ws[i]    = 8'($urandom);
                wflip[i] = ($urandom_range(0, 15) == 0);
            end
            bp_b = $urandom_range(0, 3);
            bp_r = $urandom_range(0, 2);
            do_write(4'($urandom), addr, len, size, burst);
            if ($urandom_range(0, 1) == 0) begin
                size = 3'd3;
                burst = 2'b01;
            end
            do_read(4'($urandom), addr, len, size, burst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
